// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared memory port, ALU muxes, PC and register-file enables.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcen,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] EXECUTE = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] JUMP    = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;

  // State register; reset drops any in-flight instruction back to fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state and Moore outputs; write strobes are masked while in reset.
  always_comb begin
    next_state = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        alusrcb    = 2'b01;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default: begin
            next_state = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        next_state = ALUWB;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default: begin
            next_state = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    if (!reset) begin
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .instr_done(instr_done), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU op a legal R-type funct should select; -1 means the funct is unsupported.
  function automatic int r_aluop(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // Runs one instruction from FETCH to its final cycle. fw/mw: ready-low cycles
  // to insert in FETCH and in the memory access (-1 = random).
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifunct,
                           input logic iz, input int fw, input int mw);
    int path[$];
    int idx, waited, st, lim, done_cnt, wr_cnt, rw_cnt, mem_waits;
    bit mr, waitable, last, writes_reg, is_illegal, is_sw;
    int rop;

    rop        = r_aluop(ifunct);
    writes_reg = 1'b0;
    is_illegal = 1'b0;
    is_sw      = 1'b0;
    case (iop)
      6'b100011: begin path = '{0, 1, 2, 3, 4}; writes_reg = 1'b1; end
      6'b101011: begin path = '{0, 1, 2, 5}; is_sw = 1'b1; end
      6'b000000: begin
        if (rop >= 0) begin path = '{0, 1, 6, 7}; writes_reg = 1'b1; end
        else          begin path = '{0, 1, 6}; is_illegal = 1'b1; end
      end
      6'b000100: path = '{0, 1, 8};
      6'b001000: begin path = '{0, 1, 9, 10}; writes_reg = 1'b1; end
      6'b000010: path = '{0, 1, 11};
      default:   begin path = '{0, 1}; is_illegal = 1'b1; end
    endcase

    op = iop; funct = ifunct; zero = iz;
    idx = 0; waited = 0; done_cnt = 0; wr_cnt = 0; rw_cnt = 0; mem_waits = 0;
    while (idx < path.size()) begin
      st       = path[idx];
      waitable = (st == 0) || (st == 3) || (st == 5);
      if (waitable) begin
        lim = (st == 0) ? fw : mw;
        if (lim < 0) mr = ($urandom_range(0, 3) != 0);
        else         mr = (waited >= lim);
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      mem_ready = mr;
      #1;
      last = (idx == path.size() - 1) && (!waitable || mr);
      check("state",      32'(dbg_state), 32'(st));
      check("instr_done", 32'(instr_done), 32'(last));
      check("illegal_op", 32'(illegal_op), 32'(last && is_illegal));
      check("regwrite",   32'(regwrite), 32'(last && writes_reg));
      check("memwrite",   32'(memwrite), 32'(is_sw && st == 5));
      check("irwrite",    32'(irwrite), 32'(st == 0 && mr));
      check("pcen",       32'(pcen), 32'((st == 0 && mr) || st == 11 || (st == 8 && iz)));
      check("iord",       32'(iord), 32'(st == 3 || st == 5));
      check("memtoreg",   32'(memtoreg), 32'(st == 4));
      check("regdst",     32'(regdst), 32'(st == 7));
      check("pcsrc",      32'(pcsrc), (st == 8) ? 32'd1 : (st == 11) ? 32'd2 : 32'd0);
      check("alucontrol", 32'(alucontrol),
            (st == 6 && rop >= 0) ? 32'(rop) : (st == 8) ? 32'd6 : 32'd2);
      if (st == 0) check("alusrcb_fetch", 32'(alusrcb), 32'd1);
      if (st == 1) check("alusrcb_dec",   32'(alusrcb), 32'd3);
      done_cnt += int'(instr_done);
      wr_cnt   += int'(memwrite);
      rw_cnt   += int'(regwrite);
      @(negedge clk);
      if (waitable && !mr) begin
        waited++;
        if (st != 0) mem_waits++;
      end else begin
        idx++;
        waited = 0;
      end
    end
    check("done_per_instr", 32'(done_cnt), 32'd1);
    check("regwrite_per_instr", 32'(rw_cnt), 32'(writes_reg));
    if (is_sw) check("memwrite_cycles", 32'(wr_cnt), 32'(mem_waits + 1));
  endtask

  initial begin
    logic [5:0] rop_pool [6];
    logic [5:0] rfun_pool[5];
    logic [5:0] o, f;

    rop_pool  = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    rfun_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b0; op = 6'b000010; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state",      32'(dbg_state), 32'd0);
    check("rst_irwrite",    32'(irwrite), 32'd0);
    check("rst_pcen",       32'(pcen), 32'd0);
    check("rst_regwrite",   32'(regwrite), 32'd0);
    check("rst_memwrite",   32'(memwrite), 32'd0);
    check("rst_done",       32'(instr_done), 32'd0);
    check("rst_alusrcb",    32'(alusrcb), 32'd1);
    check("rst_alucontrol", 32'(alucontrol), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rel_state_decode", 32'(dbg_state), 32'd1);
    @(negedge clk); #1;
    check("rel_state_jump", 32'(dbg_state), 32'd11);
    @(negedge clk);

    // Directed cases from the plan.
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw, no waits
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);   // sub
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);   // sw, 3 wait cycles
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal op
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);   // illegal funct
    run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);   // addi, fetch waits
    run_instr(6'b100011, 6'b000000, 1'b0, 1, 2);   // lw, read waits

    // Reset in the middle of a store: abandon at once, no strobes.
    op = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("mid_state_memwr", 32'(dbg_state), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state",    32'(dbg_state), 32'd0);
    check("mid_rst_memwrite", 32'(memwrite), 32'd0);
    check("mid_rst_iord",     32'(iord), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random instruction stream.
    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, 7));
      if (k < 6) o = rop_pool[k];
      else begin
        do o = 6'($urandom); while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                                    o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
      end
      if ($urandom_range(0, 5) == 0) f = 6'($urandom);
      else                           f = rfun_pool[$urandom_range(0, 4)];
      run_instr(o, f, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style sequencer for the multicycle MIPS datapath. It replaces the combinational single-cycle control path with a 12-state FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared memory port, ALU operand muxes, PC and register-file enables. It also inserts wait states on a memory ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the dbg_state port

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  6  instruction opcode from the instruction register
funct  input  6  R-type function field
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
pcen  output  1  PC load enable
regdst  output  1  write register select: 1 = rd, 0 = rt
memtoreg  output  1  writeback select: 1 = memory data, 0 = ALUOut
regwrite  output  1  register file write
alusrca  output  1  ALU A select: 0 = PC, 1 = register A
alusrcb  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signimm, 11 = signimm<<2
pcsrc  output  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  output  3  ALU operation
instr_done  output  1  one-cycle pulse on the last cycle of every instruction
illegal_op  output  1  one-cycle pulse on an unsupported op or funct
dbg_state  output  STATE_W  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- The state register is the only sequential element. All outputs are combinational from state, plus mem_ready, zero and funct where noted.
- Reset:
  - reset=0 asynchronously forces state to FETCH.
  - While reset=0: irwrite, pcen, regwrite, memwrite, instr_done and illegal_op are forced to 0.
  - All other outputs show FETCH values: alusrcb=01, alucontrol=010, all remaining outputs 0.
- Default value of every output is 0 unless listed below. alucontrol defaults to 010 (add).
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010.
  - irwrite=pcen=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal_op=1 and instr_done=1 in this cycle.
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next state is MEMRD if op=lw, else MEMWR.
- MEMRD: iord=1. Wait while mem_ready=0, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, held for the whole wait. instr_done=mem_ready. Go to FETCH when mem_ready=1.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010, with illegal_op=1 and instr_done=1, next state FETCH (no writeback).
  - For a legal funct, next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero, instr_done=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Next state FETCH.
- Unused encodings 12-15 -> FETCH next cycle. All outputs take default values in these states.
- Latency with mem_ready held at 1: lw=5 cycles, sw=4, R-type=4, addi=4, beq=3, j=3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset mid-instruction abandons it immediately, with no further write strobes. After release, execution resumes at FETCH.

Test Plan:
- Reset: hold reset=0, mem_ready=1 -> dbg_state=0, irwrite=pcen=regwrite=memwrite=0, alusrcb=01. Release reset -> next edge gives dbg_state=1.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4. iord=1 in state 3. regwrite=1, memtoreg=1 in state 4. instr_done pulses once; 5 cycles total.
- R-type sub (funct=100010) -> states 0,1,6,7. alucontrol=110 in state 6. regdst=1, regwrite=1 in state 7.
- beq with zero=1, then zero=0 -> pcen=1 with pcsrc=01 in state 8 for the first; pcen=0 for the second. Both return to state 0.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite high for 4 consecutive cycles. instr_done pulses only on the final cycle; next state 0.
- op=111111 -> illegal_op=1 and instr_done=1 in DECODE, next state 0, no regwrite/memwrite. A second case with funct=000000 in EXECUTE gives the same response.
